// File: rtl/id_exe_reg_pkg.sv
// rtl/id_exe_reg_pkg.sv - shared decode/execute constants
// Purpose: status-register bit positions, ALU command encodings and field
//          widths shared by the ID stage and the ID/EXE pipeline register.
// Ports:   none (package)
package id_exe_reg_pkg;

    // Status register bit positions within {N,Z,C,V}
    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;
    localparam int SR_W = 4;

    // Field widths
    localparam int CMD_W      = 4;
    localparam int REG_W      = 4;
    localparam int SHIFT_OP_W = 12;
    localparam int SIMM24_W   = 24;

    // ALU command encodings. Several opcodes share a command (e.g. SUB/CMP),
    // so these are plain constants rather than an enum.
    localparam logic [CMD_W-1:0] EXE_NOP = 4'b0000;
    localparam logic [CMD_W-1:0] EXE_MOV = 4'b0001;
    localparam logic [CMD_W-1:0] EXE_ADD = 4'b0010;
    localparam logic [CMD_W-1:0] EXE_ADC = 4'b0011;
    localparam logic [CMD_W-1:0] EXE_SUB = 4'b0100;
    localparam logic [CMD_W-1:0] EXE_SBC = 4'b0101;
    localparam logic [CMD_W-1:0] EXE_AND = 4'b0110;
    localparam logic [CMD_W-1:0] EXE_ORR = 4'b0111;
    localparam logic [CMD_W-1:0] EXE_EOR = 4'b1000;
    localparam logic [CMD_W-1:0] EXE_MVN = 4'b1001;

endpackage

// File: rtl/id_exe_reg_if.sv
// rtl/id_exe_reg_if.sv - decode-stage bundle interface
// Purpose: carries the ID control bits and operands into the ID/EXE register.
// Modports: master (ID stage drives), slave (ID/EXE register receives).
interface id_exe_reg_if #(
    parameter int DW = 32
);
    import id_exe_reg_pkg::*;

    logic                  wb_en;
    logic                  mem_r;
    logic                  mem_w;
    logic                  b;
    logic                  s;
    logic [CMD_W-1:0]      exe_cmd;
    logic [DW-1:0]         pc;
    logic [DW-1:0]         val_rn;
    logic [DW-1:0]         val_rm;
    logic [REG_W-1:0]      dest;
    logic                  imm;
    logic [SHIFT_OP_W-1:0] shift_op;
    logic [SIMM24_W-1:0]   simm24;

    modport master (
        output wb_en, mem_r, mem_w, b, s, exe_cmd,
        output pc, val_rn, val_rm, dest, imm, shift_op, simm24
    );

    modport slave (
        input wb_en, mem_r, mem_w, b, s, exe_cmd,
        input pc, val_rn, val_rm, dest, imm, shift_op, simm24
    );

endinterface

// File: rtl/id_exe_reg_status_reg.sv
// rtl/id_exe_reg_status_reg.sv - N/Z/C/V status register
// Purpose: four flag flops with load enable feeding the ID condition check.
// Ports:   clk, rst (async active-low), en (load), d {N,Z,C,V}, q {N,Z,C,V}
module id_exe_reg_status_reg
    import id_exe_reg_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [SR_W-1:0] d,
    output logic [SR_W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_exe_reg.sv
// rtl/id_exe_reg.sv - ID/EXE pipeline register with bubble insert and status register
// Purpose: captures the decode bundle, inserts bubbles on flush/hazard, holds on
//          memory stall, counts bubbles (saturating) and owns the N/Z/C/V flags.
// Ports:   clk, rst (async active-low); id (decode bundle, slave modport);
//          hazard, flush, mem_stall; alu_s, alu_flags {N,Z,C,V};
//          exe_* registered bundle, exe_valid; sr_n/z/c/v; bubble_cnt.
module id_exe_reg
    import id_exe_reg_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 16
)(
    input  logic                  clk,
    input  logic                  rst,
    id_exe_reg_if.slave           id,
    input  logic                  hazard,
    input  logic                  flush,
    input  logic                  mem_stall,
    input  logic                  alu_s,
    input  logic [SR_W-1:0]       alu_flags,
    output logic                  exe_wb_en,
    output logic                  exe_mem_r,
    output logic                  exe_mem_w,
    output logic                  exe_b,
    output logic                  exe_s,
    output logic [CMD_W-1:0]      exe_exe_cmd,
    output logic [DW-1:0]         exe_pc,
    output logic [DW-1:0]         exe_val_rn,
    output logic [DW-1:0]         exe_val_rm,
    output logic [REG_W-1:0]      exe_dest,
    output logic                  exe_imm,
    output logic [SHIFT_OP_W-1:0] exe_shift_op,
    output logic [SIMM24_W-1:0]   exe_simm24,
    output logic                  exe_valid,
    output logic                  sr_n,
    output logic                  sr_z,
    output logic                  sr_c,
    output logic                  sr_v,
    output logic [CNT_W-1:0]      bubble_cnt
);

    // flush and hazard in the same cycle produce a single bubble
    logic            bubble;
    logic            sr_en;
    logic [SR_W-1:0] sr_q;

    assign bubble = flush | hazard;

    // Flags come from the instruction already in EXE, so only a real
    // instruction there may write them, and never while the pipe is frozen.
    assign sr_en = ~mem_stall & exe_valid & alu_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_wb_en    <= 1'b0;
            exe_mem_r    <= 1'b0;
            exe_mem_w    <= 1'b0;
            exe_b        <= 1'b0;
            exe_s        <= 1'b0;
            exe_exe_cmd  <= EXE_NOP;
            exe_pc       <= '0;
            exe_val_rn   <= '0;
            exe_val_rm   <= '0;
            exe_dest     <= '0;
            exe_imm      <= 1'b0;
            exe_shift_op <= '0;
            exe_simm24   <= '0;
            exe_valid    <= 1'b0;
            bubble_cnt   <= '0;
        end else if (!mem_stall) begin
            // Data fields load unconditionally; with controls zeroed they are inert.
            exe_pc       <= id.pc;
            exe_val_rn   <= id.val_rn;
            exe_val_rm   <= id.val_rm;
            exe_dest     <= id.dest;
            exe_imm      <= id.imm;
            exe_shift_op <= id.shift_op;
            exe_simm24   <= id.simm24;
            if (bubble) begin
                exe_wb_en   <= 1'b0;
                exe_mem_r   <= 1'b0;
                exe_mem_w   <= 1'b0;
                exe_b       <= 1'b0;
                exe_s       <= 1'b0;
                exe_exe_cmd <= EXE_NOP;
                exe_valid   <= 1'b0;
                if (bubble_cnt != {CNT_W{1'b1}}) begin
                    bubble_cnt <= bubble_cnt + CNT_W'(1);
                end
            end else begin
                exe_wb_en   <= id.wb_en;
                exe_mem_r   <= id.mem_r;
                exe_mem_w   <= id.mem_w;
                exe_b       <= id.b;
                exe_s       <= id.s;
                exe_exe_cmd <= id.exe_cmd;
                exe_valid   <= 1'b1;
            end
        end
    end

    id_exe_reg_status_reg u_status_reg (
        .clk (clk),
        .rst (rst),
        .en  (sr_en),
        .d   (alu_flags),
        .q   (sr_q)
    );

    assign sr_n = sr_q[SR_N];
    assign sr_z = sr_q[SR_Z];
    assign sr_c = sr_q[SR_C];
    assign sr_v = sr_q[SR_V];

endmodule

// File: tb/tb_id_exe_reg.sv
// tb/tb_id_exe_reg.sv - directed self-checking bench for id_exe_reg
module tb_id_exe_reg;
    import id_exe_reg_pkg::*;

    localparam int DW    = 32;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic hazard, flush, mem_stall, alu_s;
    logic [3:0] alu_flags;

    logic exe_wb_en, exe_mem_r, exe_mem_w, exe_b, exe_s, exe_imm, exe_valid;
    logic [3:0] exe_exe_cmd, exe_dest;
    logic [DW-1:0] exe_pc, exe_val_rn, exe_val_rm;
    logic [11:0] exe_shift_op;
    logic [23:0] exe_simm24;
    logic sr_n, sr_z, sr_c, sr_v;
    logic [CNT_W-1:0] bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    id_exe_reg_if #(.DW(DW)) id_bus ();

    id_exe_reg #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id           (id_bus),
        .hazard       (hazard),
        .flush        (flush),
        .mem_stall    (mem_stall),
        .alu_s        (alu_s),
        .alu_flags    (alu_flags),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r    (exe_mem_r),
        .exe_mem_w    (exe_mem_w),
        .exe_b        (exe_b),
        .exe_s        (exe_s),
        .exe_exe_cmd  (exe_exe_cmd),
        .exe_pc       (exe_pc),
        .exe_val_rn   (exe_val_rn),
        .exe_val_rm   (exe_val_rm),
        .exe_dest     (exe_dest),
        .exe_imm      (exe_imm),
        .exe_shift_op (exe_shift_op),
        .exe_simm24   (exe_simm24),
        .exe_valid    (exe_valid),
        .sr_n         (sr_n),
        .sr_z         (sr_z),
        .sr_c         (sr_c),
        .sr_v         (sr_v),
        .bubble_cnt   (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic wb, input logic [3:0] cmd, input logic s,
                          input logic [31:0] pc, input logic [31:0] rn);
        id_bus.wb_en    = wb;
        id_bus.mem_r    = 1'b0;
        id_bus.mem_w    = 1'b0;
        id_bus.b        = 1'b0;
        id_bus.s        = s;
        id_bus.exe_cmd  = cmd;
        id_bus.pc       = pc;
        id_bus.val_rn   = rn;
        id_bus.val_rm   = 32'h5555_0000;
        id_bus.dest     = 4'd7;
        id_bus.imm      = 1'b1;
        id_bus.shift_op = 12'hABC;
        id_bus.simm24   = 24'h123456;
    endtask

    function automatic logic [3:0] sr();
        return {sr_n, sr_z, sr_c, sr_v};
    endfunction

    function automatic logic [5:0] ctrl();
        return {exe_wb_en, exe_mem_r, exe_mem_w, exe_b, exe_s, exe_valid};
    endfunction

    initial begin
        // 1: reset with garbage inputs
        id_bus.wb_en = 1; id_bus.mem_r = 1; id_bus.mem_w = 1; id_bus.b = 1; id_bus.s = 1;
        id_bus.exe_cmd = 4'hF; id_bus.pc = 32'hFFFF_FFFF; id_bus.val_rn = 32'hCAFE_F00D;
        id_bus.val_rm = 32'h1111_2222; id_bus.dest = 4'hE; id_bus.imm = 1;
        id_bus.shift_op = 12'hFFF; id_bus.simm24 = 24'hFFFFFF;
        hazard = 1; flush = 0; mem_stall = 0; alu_s = 1; alu_flags = 4'hF;
        step(); step();
        check("rst_valid", 32'(exe_valid), 32'd0);
        check("rst_ctrl", 32'(ctrl()), 32'd0);
        check("rst_cmd", 32'(exe_exe_cmd), 32'd0);
        check("rst_pc", exe_pc, 32'd0);
        check("rst_rn", exe_val_rn, 32'd0);
        check("rst_simm", 32'(exe_simm24), 32'd0);
        check("rst_sr", 32'(sr()), 32'd0);
        check("rst_cnt", 32'(bubble_cnt), 32'd0);

        rst = 1; hazard = 0; alu_s = 0; alu_flags = 4'h0;

        // 2: normal load
        set_id(1'b1, EXE_ADD, 1'b0, 32'h100, 32'h1234);
        step();
        check("load_cmd", 32'(exe_exe_cmd), 32'd2);
        check("load_wb", 32'(exe_wb_en), 32'd1);
        check("load_rn", exe_val_rn, 32'h1234);
        check("load_valid", 32'(exe_valid), 32'd1);
        check("load_shift", 32'(exe_shift_op), 32'hABC);
        check("load_cnt", 32'(bubble_cnt), 32'd0);

        // 4: SR update from valid EXE with alu_s=1
        set_id(1'b1, EXE_SUB, 1'b1, 32'h104, 32'h2);
        alu_s = 1; alu_flags = 4'b0100;
        step();
        check("sr_set", 32'(sr()), 32'b0100);
        check("sr_set_cmd", 32'(exe_exe_cmd), 32'd4);
        alu_s = 0; alu_flags = 4'b1011;
        set_id(1'b0, EXE_MOV, 1'b0, 32'h108, 32'h3);
        step();
        check("sr_hold_s0", 32'(sr()), 32'b0100);

        // 3: flush+hazard -> single bubble
        flush = 1; hazard = 1;
        set_id(1'b1, EXE_SBC, 1'b1, 32'h10C, 32'hAAAA);
        step();
        check("bub_ctrl", 32'(ctrl()), 32'd0);
        check("bub_cmd", 32'(exe_exe_cmd), 32'd0);
        check("bub_cnt", 32'(bubble_cnt), 32'd1);
        check("bub_data", exe_val_rn, 32'hAAAA);
        // bubble in EXE with alu_s=1 must not touch SR
        flush = 0; hazard = 0; alu_s = 1; alu_flags = 4'b1111;
        set_id(1'b1, EXE_ORR, 1'b0, 32'h110, 32'h77);
        step();
        check("bub_no_sr", 32'(sr()), 32'b0100);
        check("after_bub_valid", 32'(exe_valid), 32'd1);
        // stall beats flush
        mem_stall = 1; flush = 1; alu_flags = 4'b0001;
        set_id(1'b0, EXE_EOR, 1'b0, 32'h114, 32'h99);
        step();
        check("stall_fl_cmd", 32'(exe_exe_cmd), 32'd7);
        check("stall_fl_valid", 32'(exe_valid), 32'd1);
        check("stall_fl_rn", exe_val_rn, 32'h77);
        check("stall_fl_cnt", 32'(bubble_cnt), 32'd1);
        check("stall_fl_sr", 32'(sr()), 32'b0100);

        // 5: stall hold
        mem_stall = 0; flush = 0; alu_s = 0;
        set_id(1'b1, EXE_AND, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        step();
        check("hold_load_rn", exe_val_rn, 32'hDEAD_BEEF);
        mem_stall = 1; alu_s = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b0, 4'(i + 1), 1'b0, 32'(i), 32'(i * 3));
            alu_flags = 4'(4'b1000 >> i);
            step();
            check("hold_rn", exe_val_rn, 32'hDEAD_BEEF);
            check("hold_pc", exe_pc, 32'hDEAD_BEEF);
            check("hold_cmd", 32'(exe_exe_cmd), 32'd6);
            check("hold_sr", 32'(sr()), 32'b0100);
        end

        // 6: saturation with CNT_W=4
        mem_stall = 0; alu_s = 0; hazard = 1;
        for (int i = 0; i < 5; i++) step();
        check("sat_mid", 32'(bubble_cnt), 32'd6);
        for (int i = 0; i < 15; i++) step();
        check("sat_full", 32'(bubble_cnt), 32'hF);
        check("sat_valid", 32'(exe_valid), 32'd0);
        // async reset mid-burst
        #2 rst = 0;
        #1;
        check("arst_cnt", 32'(bubble_cnt), 32'd0);
        check("arst_pc", exe_pc, 32'd0);
        check("arst_sr", 32'(sr()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
